axis_stream_monitor: RTL and testbench

Passive multi-channel AXI-Stream tap monitor, parametrised in channel count and datapath width. It sits beside MAC TX/RX streams and packet generator outputs without driving any handshake signal. Per channel it counts frames, bytes and errored frames, and captures the first data word of the most recent frame. Statistics are exposed on an AXI-Lite slave (XFCP-reachable), and the first byte of the most recent frame on a selected channel drives the board LEDs.

---
 rtl/axis_stream_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_axis_stream_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_monitor.sv
// axis_stream_monitor
//   Passive AXI-Stream tap monitor. For every channel it counts frames, bytes
//   and errored frames, tracks whether a frame is open, and keeps the low 32
//   bits of the first beat of the most recent frame. Statistics are read over
//   an AXI-Lite slave. The first byte of the latest frame on LED_CHANNEL
//   drives led.
//
//   Ports
//     clk, rst_n        : single clock, asynchronous active-low reset
//     mon_axis_*        : tapped streams, channel i in slice i (inputs only)
//     s_axil_*          : AXI-Lite slave, one read and one write outstanding
//     led               : first byte of the last frame seen on LED_CHANNEL
//
//   Register map (channel base = i*0x20)
//     0x00 frame_cnt (any write clears all three counters of the channel)
//     0x04 byte_cnt   0x08 err_cnt   0x0C capture
//     0x10 status     bit0 in_frame, bit1 any counter saturated
//     0x14 timestamp  (0 unless built with MON_TIMESTAMP_EN)
//
//   Build option: define MON_TIMESTAMP_EN to latch a free-running cycle
//   count into a per-channel register on every tlast beat.
module axis_stream_monitor #(
  parameter int N_CHANNELS      = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int COUNT_WIDTH     = 32,
  parameter int LED_CHANNEL     = 0,
  parameter int AXIL_ADDR_WIDTH = 16,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] mon_axis_tdata,
  input  logic [N_CHANNELS*KEEP_WIDTH-1:0] mon_axis_tkeep,
  input  logic [N_CHANNELS-1:0]           mon_axis_tvalid,
  input  logic [N_CHANNELS-1:0]           mon_axis_tready,
  input  logic [N_CHANNELS-1:0]           mon_axis_tlast,
  input  logic [N_CHANNELS-1:0]           mon_axis_tuser,
  input  logic [AXIL_ADDR_WIDTH-1:0]      s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]      s_axil_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]    s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]      s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [7:0]                      led
);

  localparam int CHW = AXIL_ADDR_WIDTH - 5;
  localparam int PW  = $clog2(KEEP_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [PW-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [PW-1:0] n;
    n = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) n = n + PW'(k[b]);
    return n;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                      input logic [PW-1:0] inc);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + (COUNT_WIDTH+1)'(inc);
    return sum[COUNT_WIDTH] ? CNT_MAX : sum[COUNT_WIDTH-1:0];
  endfunction

  logic [COUNT_WIDTH-1:0] frame_cnt_q [N_CHANNELS];
  logic [COUNT_WIDTH-1:0] frame_cnt_d [N_CHANNELS];
  logic [COUNT_WIDTH-1:0] byte_cnt_q  [N_CHANNELS];
  logic [COUNT_WIDTH-1:0] byte_cnt_d  [N_CHANNELS];
  logic [COUNT_WIDTH-1:0] err_cnt_q   [N_CHANNELS];
  logic [COUNT_WIDTH-1:0] err_cnt_d   [N_CHANNELS];
  logic [31:0]            capture_q   [N_CHANNELS];
  logic [31:0]            capture_d   [N_CHANNELS];
  logic [N_CHANNELS-1:0]  in_frame_q, in_frame_d;
  logic [N_CHANNELS-1:0]  clr;
  logic [7:0]             led_q, led_d;

  logic                       awready_q, bvalid_q, arready_q, rvalid_q;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rd_val;
  logic                       wr_hs, rd_hs;
  logic [CHW-1:0]             wr_ch, rd_ch;
  logic [2:0]                 wr_off, rd_off;

  assign wr_hs  = s_axil_awvalid & s_axil_wvalid & awready_q;
  assign rd_hs  = s_axil_arvalid & arready_q;
  assign wr_ch  = s_axil_awaddr[AXIL_ADDR_WIDTH-1:5];
  assign wr_off = s_axil_awaddr[4:2];
  assign rd_ch  = s_axil_araddr[AXIL_ADDR_WIDTH-1:5];
  assign rd_off = s_axil_araddr[4:2];

`ifdef MON_TIMESTAMP_EN
  logic [COUNT_WIDTH-1:0] cyc_q;
  logic [COUNT_WIDTH-1:0] ts_q [N_CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      for (int i = 0; i < N_CHANNELS; i++) ts_q[i] <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      for (int i = 0; i < N_CHANNELS; i++)
        if (mon_axis_tvalid[i] & mon_axis_tready[i] & mon_axis_tlast[i]) ts_q[i] <= cyc_q;
    end
  end
`endif

  // Clear has priority over a coincident beat; in_frame/capture ignore clear.
  always_comb begin
    led_d = led_q;
    for (int i = 0; i < N_CHANNELS; i++) begin
      clr[i]         = wr_hs && (wr_ch == CHW'(i)) && (wr_off == 3'd0);
      frame_cnt_d[i] = frame_cnt_q[i];
      byte_cnt_d[i]  = byte_cnt_q[i];
      err_cnt_d[i]   = err_cnt_q[i];
      capture_d[i]   = capture_q[i];
      in_frame_d[i]  = in_frame_q[i];
      if (mon_axis_tvalid[i] & mon_axis_tready[i]) begin
        in_frame_d[i] = ~mon_axis_tlast[i];
        if (!in_frame_q[i]) begin
          capture_d[i] = 32'(mon_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]);
          if (i == LED_CHANNEL) led_d = mon_axis_tdata[i*DATA_WIDTH +: 8];
        end
        if (!clr[i]) begin
          byte_cnt_d[i] = sat_add(byte_cnt_q[i], popcount(mon_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]));
          if (mon_axis_tlast[i]) begin
            frame_cnt_d[i] = sat_add(frame_cnt_q[i], PW'(1));
            if (mon_axis_tuser[i]) err_cnt_d[i] = sat_add(err_cnt_q[i], PW'(1));
          end
        end
      end
      if (clr[i]) begin
        frame_cnt_d[i] = '0;
        byte_cnt_d[i]  = '0;
        err_cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        frame_cnt_q[i] <= '0;
        byte_cnt_q[i]  <= '0;
        err_cnt_q[i]   <= '0;
        capture_q[i]   <= '0;
      end
      in_frame_q <= '0;
      led_q      <= '0;
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        frame_cnt_q[i] <= frame_cnt_d[i];
        byte_cnt_q[i]  <= byte_cnt_d[i];
        err_cnt_q[i]   <= err_cnt_d[i];
        capture_q[i]   <= capture_d[i];
      end
      in_frame_q <= in_frame_d;
      led_q      <= led_d;
    end
  end

  // Out-of-range channel or offset falls through to 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (rd_ch == CHW'(i)) begin
        case (rd_off)
          3'd0: rd_val = AXIL_DATA_WIDTH'(frame_cnt_q[i]);
          3'd1: rd_val = AXIL_DATA_WIDTH'(byte_cnt_q[i]);
          3'd2: rd_val = AXIL_DATA_WIDTH'(err_cnt_q[i]);
          3'd3: rd_val = AXIL_DATA_WIDTH'(capture_q[i]);
          3'd4: rd_val = AXIL_DATA_WIDTH'({(frame_cnt_q[i] == CNT_MAX) ||
                                           (byte_cnt_q[i] == CNT_MAX) ||
                                           (err_cnt_q[i] == CNT_MAX), in_frame_q[i]});
`ifdef MON_TIMESTAMP_EN
          3'd5: rd_val = AXIL_DATA_WIDTH'(ts_q[i]);
`endif
          default: rd_val = '0;
        endcase
      end
    end
  end

  // The ~*ready_q terms keep the ready strobes to a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~awready_q;
      if (wr_hs)              bvalid_q <= 1'b1;
      else if (s_axil_bready) bvalid_q <= 1'b0;
      arready_q <= s_axil_arvalid & ~rvalid_q & ~arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;
  assign led            = led_q;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_wdata,
                       s_axil_awaddr[1:0], s_axil_araddr[1:0], mon_axis_tdata};

endmodule

// File: tb/tb_axis_stream_monitor.sv
module tb_axis_stream_monitor;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*DW-1:0] m_tdata;
  logic [N*KW-1:0] m_tkeep;
  logic [N-1:0]  m_tvalid, m_tready, m_tlast, m_tuser;
  logic [15:0]   awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [7:0]    led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_stream_monitor #(
    .N_CHANNELS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .COUNT_WIDTH(16),
    .LED_CHANNEL(0), .AXIL_ADDR_WIDTH(16), .AXIL_DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mon_axis_tdata(m_tdata), .mon_axis_tkeep(m_tkeep), .mon_axis_tvalid(m_tvalid),
    .mon_axis_tready(m_tready), .mon_axis_tlast(m_tlast), .mon_axis_tuser(m_tuser),
    .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
    .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready), .led(led)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_stream();
    m_tvalid = '0; m_tready = '0; m_tlast = '0; m_tuser = '0;
  endtask

  // One handshake beat on channel ch; returns on the negedge after the beat.
  task automatic beat(input int ch, input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u);
    @(negedge clk);
    idle_stream();
    m_tdata[ch*DW +: DW] = d;
    m_tkeep[ch*KW +: KW] = k;
    m_tvalid[ch] = 1'b1; m_tready[ch] = 1'b1;
    m_tlast[ch]  = l;    m_tuser[ch]  = u;
    @(negedge clk);
    idle_stream();
  endtask

  task automatic axil_read(input logic [15:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check($sformatf("arready@%h", addr), {31'b0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check($sformatf("rvalid_lat@%h", addr), {31'b0, rvalid}, 32'd1);
    check($sformatf("rresp@%h", addr), {30'b0, rresp}, 32'd0);
    data = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic axil_write(input logic [15:0] addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check($sformatf("awready@%h", addr), {30'b0, awready, wready}, 32'd3);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check($sformatf("bvalid_lat@%h", addr), {31'b0, bvalid}, 32'd1);
    check($sformatf("bresp@%h", addr), {30'b0, bresp}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic [31:0] e_frame, e_byte, e_err, e_cap, e_stat;
    logic [7:0]  e_led;
  } vec_t;

  vec_t vec [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    logic [15:0] base;
    int n;

    vec[0] = '{0, 64'h0000_0000_CAFE_0033, 8'hFF, 1'b1, 1'b0, 32'd1, 32'd8,  32'd0, 32'hCAFE0033, 32'd0, 8'h33};
    vec[1] = '{1, 64'h1111_2222_DEAD_BEEF, 8'hFF, 1'b0, 1'b0, 32'd0, 32'd8,  32'd0, 32'hDEADBEEF, 32'd1, 8'h33};
    vec[2] = '{1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0, 32'd0, 32'd16, 32'd0, 32'hDEADBEEF, 32'd1, 8'h33};
    vec[3] = '{1, 64'hFFFF_FFFF_0000_0001, 8'h0F, 1'b1, 1'b0, 32'd1, 32'd20, 32'd0, 32'hDEADBEEF, 32'd0, 8'h33};
    vec[4] = '{0, 64'h0000_0000_0000_00A5, 8'hFF, 1'b1, 1'b1, 32'd2, 32'd16, 32'd1, 32'h000000A5, 32'd0, 8'hA5};
    vec[5] = '{2, 64'h0000_0000_0000_005A, 8'hFF, 1'b1, 1'b1, 32'd1, 32'd8,  32'd1, 32'h0000005A, 32'd0, 8'hA5};
    vec[6] = '{2, 64'h0000_0000_0000_0077, 8'h01, 1'b0, 1'b1, 32'd1, 32'd9,  32'd1, 32'h00000077, 32'd1, 8'hA5};
    vec[7] = '{2, 64'h0000_0000_0000_0088, 8'h80, 1'b1, 1'b1, 32'd2, 32'd10, 32'd2, 32'h00000077, 32'd0, 8'hA5};

    rst_n = 1'b0;
    m_tdata = '0; m_tkeep = '0; idle_stream();
    awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_led", {24'b0, led}, 32'h0);

    // Reset asserted while ch0 is mid-frame.
    beat(0, 64'h11, 8'hFF, 1'b0, 1'b0);
    check("led_pre_reset", {24'b0, led}, 32'h11);
    #2 rst_n = 1'b0;
    #1 check("led_async_reset", {24'b0, led}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axil_read(16'h0000, rd); check("rst_frame0", rd, 0);
    axil_read(16'h0004, rd); check("rst_byte0", rd, 0);
    axil_read(16'h000C, rd); check("rst_cap0", rd, 0);
    axil_read(16'h0010, rd); check("rst_status0", rd, 0);

    for (int v = 0; v < 8; v++) begin
      beat(vec[v].ch, vec[v].data, vec[v].keep, vec[v].last, vec[v].user);
      check($sformatf("v%0d_led", v), {24'b0, led}, {24'b0, vec[v].e_led});
      base = 16'(vec[v].ch * 32);
      axil_read(base + 16'h00, rd); check($sformatf("v%0d_frame", v), rd, vec[v].e_frame);
      axil_read(base + 16'h04, rd); check($sformatf("v%0d_byte", v),  rd, vec[v].e_byte);
      axil_read(base + 16'h08, rd); check($sformatf("v%0d_err", v),   rd, vec[v].e_err);
      axil_read(base + 16'h0C, rd); check($sformatf("v%0d_cap", v),   rd, vec[v].e_cap);
      axil_read(base + 16'h10, rd); check($sformatf("v%0d_stat", v),  rd, vec[v].e_stat);
    end

    // ch3 stalled for 10 cycles, then a single handshake.
    @(negedge clk);
    m_tkeep[3*KW +: KW] = 8'hFF; m_tvalid[3] = 1'b1; m_tlast[3] = 1'b1;
    repeat (10) @(negedge clk);
    m_tready[3] = 1'b1;
    @(negedge clk);
    idle_stream();
    axil_read(16'h0064, rd); check("stall_byte", rd, 8);
    axil_read(16'h0060, rd); check("stall_frame", rd, 1);

    // Clear write and read of ch3 byte_cnt accepted in the same cycle.
    fork
      axil_write(16'h0060, 32'h0000_DEAD);
      axil_read(16'h0064, rd2);
    join
    check("conc_read_preclear", rd2, 8);
    axil_read(16'h0064, rd); check("clr_byte", rd, 0);
    axil_read(16'h0060, rd); check("clr_frame", rd, 0);

    // Preload ch3 byte_cnt to 0xFFF8 with 8191 full beats in one open frame.
    @(negedge clk);
    m_tkeep[3*KW +: KW] = 8'hFF; m_tvalid[3] = 1'b1; m_tready[3] = 1'b1;
    repeat (8191) @(negedge clk);
    idle_stream();
    axil_read(16'h0064, rd); check("pre_sat_byte", rd, 32'hFFF8);
    axil_read(16'h0070, rd); check("pre_sat_stat", rd, 1);
    beat(3, 64'h1, 8'hFF, 1'b0, 1'b0);
    axil_read(16'h0064, rd); check("sat_byte1", rd, 32'hFFFF);
    axil_read(16'h0070, rd); check("sat_stat1", rd, 3);
    beat(3, 64'h2, 8'hFF, 1'b0, 1'b0);
    axil_read(16'h0064, rd); check("sat_byte2", rd, 32'hFFFF);
    axil_write(16'h0060, 32'h0);
    axil_read(16'h0064, rd); check("sat_clr_byte", rd, 0);
    axil_read(16'h0070, rd); check("sat_clr_stat", rd, 1);
    beat(3, 64'h3, 8'hFF, 1'b0, 1'b0);
    axil_read(16'h0064, rd); check("post_clr_byte", rd, 8);

    // Clear and beat land on the same edge: the beat is dropped.
    @(negedge clk);
    awaddr = 16'h0060; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("coinc_awready", {31'b0, awready}, 32'd1);
    m_tkeep[3*KW +: KW] = 8'hFF; m_tvalid[3] = 1'b1; m_tready[3] = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; idle_stream();
    check("coinc_bvalid", {31'b0, bvalid}, 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axil_read(16'h0064, rd); check("coinc_byte", rd, 0);
    axil_read(16'h0070, rd); check("coinc_stat", rd, 1);

    // Decode holes and ignored writes.
    axil_read(16'h0080, rd); check("oob_channel", rd, 0);
    axil_read(16'h0038, rd); check("oob_offset", rd, 0);
    axil_read(16'h0034, rd); check("ts_absent", rd, 0);
    axil_write(16'h0004, 32'hFFFF_FFFF);
    axil_write(16'h0080, 32'hFFFF_FFFF);
    axil_read(16'h0004, rd); check("ignored_wr_byte0", rd, 16);
    axil_read(16'h0000, rd); check("ignored_wr_frame0", rd, 2);

    // rready held low: rvalid and rdata must stay put.
    @(negedge clk);
    araddr = 16'h0008; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("hold_arready", {31'b0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold_rvalid%0d", c), {31'b0, rvalid}, 32'd1);
      check($sformatf("hold_rdata%0d", c), rdata, 32'd1);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("hold_rvalid_drop", {31'b0, rvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
